carpim_sequencer: RTL and testbench

Control FSM for the 8-bit shift-add multiplier datapath. It takes a start request and sequences load, add and shift for a fixed number of steps, then inserts one settle cycle. It presents the product as valid with a done/ready handshake. The block owns the step counter; the datapath holds the operand and accumulator registers and returns the current multiplier LSB.

---
 rtl/carpim_sequencer.sv | 100 ++++++++++
 tb/tb_carpim_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carpim_sequencer.sv
// Control FSM for an 8-bit shift-add multiplier datapath: load, WIDTH add/shift
// steps, one settle cycle, then a done/res_ready handshake. Owns the step counter.
module carpim_sequencer #(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CW    = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          mplr_lsb,
   input  logic          res_ready,
   output logic          busy,
   output logic          load_en,
   output logic          add_en,
   output logic          shift_en,
   output logic          hold,
   output logic          done,
   output logic [CW-1:0] step_idx
);

   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_CALC = 3'd2,
      ST_HOLD = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] step_d;
   logic          busy_d;
   logic          load_d;
   logic          shift_d;
   logic          hold_d;
   logic          done_d;

   // Next state, step counter and strobes decoded from the next state so every
   // strobe leaves a flop aligned with the state it belongs to.
   always_comb begin
      state_d = state_q;
      step_d  = step_idx;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_LOAD;
         ST_LOAD: begin
            step_d  = '0;
            state_d = ST_CALC;
         end
         ST_CALC: begin
            if (step_idx == LAST_STEP) begin
               step_d  = '0;
               state_d = ST_HOLD;
            end else begin
               step_d = step_idx + CW'(1);
            end
         end
         ST_HOLD: state_d = ST_DONE;
         ST_DONE: if (res_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Cancel wins over every other transition.
      if (abort) begin
         state_d = ST_IDLE;
         step_d  = '0;
      end
      busy_d  = (state_d != ST_IDLE);
      load_d  = (state_d == ST_LOAD);
      shift_d = (state_d == ST_CALC);
      hold_d  = (state_d == ST_HOLD);
      done_d  = (state_d == ST_DONE);
   end

   // State, step counter and registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         step_idx <= '0;
         busy     <= 1'b0;
         load_en  <= 1'b0;
         shift_en <= 1'b0;
         hold     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_idx <= step_d;
         busy     <= busy_d;
         load_en  <= load_d;
         shift_en <= shift_d;
         hold     <= hold_d;
         done     <= done_d;
      end
   end

   // Only combinational output: add follows the live multiplier LSB during CALC.
   assign add_en = shift_en & mplr_lsb;

endmodule

// File: tb/tb_carpim_sequencer.sv
// Scoreboarded bench for carpim_sequencer with a small shift-add datapath model.
module tb_carpim_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, start, abort, res_ready;
   logic       mplr_lsb;
   logic       busy, load_en, add_en, shift_en, hold, done;
   logic [2:0] step_idx;

   logic       start2;
   logic       busy2, load2, add2, shift2, hold2, done2;
   logic [0:0] step2;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   logic [15:0] exp_q[$];

   // Datapath model state
   logic [7:0]  mcand, mplr;
   logic [15:0] acc;
   logic [3:0]  k;

   localparam logic [7:0]  MCAND = 8'hB5;
   localparam logic [7:0]  MPLR  = 8'h3C;
   localparam logic [15:0] PROD  = 16'h2A6C;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   carpim_sequencer #(.WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .mplr_lsb(mplr_lsb), .res_ready(res_ready), .busy(busy),
      .load_en(load_en), .add_en(add_en), .shift_en(shift_en),
      .hold(hold), .done(done), .step_idx(step_idx)
   );

   carpim_sequencer #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
      .mplr_lsb(1'b0), .res_ready(1'b1), .busy(busy2),
      .load_en(load2), .add_en(add2), .shift_en(shift2),
      .hold(hold2), .done(done2), .step_idx(step2)
   );

   // Shift-add datapath driven by the sequencer strobes
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0; mcand <= '0; mplr <= '0; k <= '0;
      end else if (load_en) begin
         acc <= '0; mcand <= MCAND; mplr <= MPLR; k <= '0;
      end else if (shift_en) begin
         if (add_en) acc <= acc + (16'(mcand) << k);
         mplr <= mplr >> 1;
         k    <= k + 4'd1;
      end
   end
   assign mplr_lsb = mplr[0];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: each accepted product is compared against the scoreboard head
   always @(negedge clk) begin
      if (rst_n && done && res_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mon_unexpected_done actual=%h required=none", acc);
         end else begin
            chk("mon_product", 32'(acc), 32'(exp_q.pop_front()));
         end
      end
   end

   function automatic logic [8:0] cur_vec();
      return {busy, load_en, shift_en, hold, done, add_en, step_idx};
   endfunction

   // Expected {busy,load,shift,hold,done,add,step} for cycle i after start (0 = LOAD)
   function automatic logic [8:0] exp_vec(input int i);
      logic [7:0] mb;
      mb = MPLR;
      if (i == 0)       return {6'b110000, 3'd0};
      else if (i <= 8)  return {5'b10100, mb[i-1], 3'(i-1)};
      else if (i == 9)  return {6'b100100, 3'd0};
      else if (i == 10) return {6'b100010, 3'd0};
      else              return 9'd0;
   endfunction

   // Pulse start for one cycle; leaves the bench just after the LOAD edge
   task automatic start_op(input bit push);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (push) exp_q.push_back(PROD);
   endtask

   // Check a full 12-cycle sequence; optionally pulse start at cycle pulse_at
   task automatic run_seq(input int pulse_at);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk($sformatf("seq_c%0d", i), 32'(cur_vec()), 32'(exp_vec(i)));
         @(posedge clk); #1;
         start = (i + 1 == pulse_at);
      end
   endtask

   int r[3];
   int n;
   int first;
   bit prev;

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1; start2 = 1'b0;
      // Reset held 3 cycles then idle for 20
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_outputs", 32'(cur_vec()), 32'd0);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_outputs", 32'(cur_vec()), 32'd0);
      end
      @(posedge clk); #1;

      // Nominal B5 x 3C
      start_op(1);
      run_seq(-1);

      // Backpressure: DONE held while res_ready=0
      res_ready = 1'b0;
      start_op(1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("bp_c%0d", i), 32'(cur_vec()), 32'(exp_vec(i)));
         @(posedge clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_done_held", 32'(cur_vec()), 32'(exp_vec(10)));
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_done", 32'(done), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_idle_after", 32'(cur_vec()), 32'd0);
      @(posedge clk); #1;

      // Start pulsed during CALC step 3 is ignored
      start_op(1);
      run_seq(4);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("ignored_start_idle", 32'({busy, done}), 32'd0);
      end
      @(posedge clk); #1;

      // Abort at CALC step 5
      start_op(0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("ab_c%0d", i), 32'(cur_vec()), 32'(exp_vec(i)));
         @(posedge clk); #1;
      end
      abort = 1'b1;
      @(negedge clk);
      chk("ab_step5", 32'(cur_vec()), 32'(exp_vec(6)));
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("ab_idle", 32'(cur_vec()), 32'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("ab_no_done", 32'({busy, done}), 32'd0);
      end
      @(posedge clk); #1;
      start_op(1);
      run_seq(-1);

      // Abort in IDLE beats start
      abort = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("abort_over_start", 32'(busy), 32'd0);
      @(posedge clk); #1;

      // Async reset during HOLD
      start_op(0);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("hold_before_reset", 32'(cur_vec()), 32'(exp_vec(9)));
      #2 rst_n = 1'b0;
      #1 chk("async_reset", 32'(cur_vec()), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_reset_idle", 32'(cur_vec()), 32'd0);
      end
      @(posedge clk); #1;

      // Back-to-back with start held high: done every 12 cycles
      repeat (3) exp_q.push_back(PROD);
      n = 0; prev = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 60 && n < 3; i++) begin
         @(negedge clk);
         if (done && !prev) begin
            r[n] = cyc;
            n++;
            if (n == 3) start = 1'b0;
         end
         prev = done;
      end
      start = 1'b0;
      chk("b2b_count", 32'(n), 32'd3);
      if (n == 3) begin
         chk("b2b_gap1", 32'(r[1] - r[0]), 32'd12);
         chk("b2b_gap2", 32'(r[2] - r[1]), 32'd12);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 14; i++) @(posedge clk);
      #1;

      // WIDTH=2 instance: done on the 5th cycle after start (index 4)
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      first = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 1) chk("w2_step0", 32'({shift2, step2}), 32'b10);
         if (i == 2) chk("w2_step1", 32'({shift2, step2}), 32'b11);
         if (i == 3) chk("w2_hold", 32'(hold2), 32'd1);
         if (done2 && first < 0) first = i;
      end
      chk("w2_done_at", 32'(first), 32'd4);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
